// File: rtl/glb_bank_arbiter.sv
// Round-robin arbiter sharing one GLB bank SRAM port among NUM_REQ requesters.
// Registers the bank command and routes read data back to the issuing requester.
module glb_bank_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int BANK_ADDR_WIDTH = 17,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int BANK_RD_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_wr,
    input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*(BANK_DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  bank_en,
    output logic                                  bank_wr,
    output logic [BANK_ADDR_WIDTH-1:0]            bank_addr,
    output logic [BANK_DATA_WIDTH-1:0]            bank_wdata,
    output logic [BANK_DATA_WIDTH/8-1:0]          bank_wstrb,
    input  logic [BANK_DATA_WIDTH-1:0]            bank_rdata,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [BANK_DATA_WIDTH-1:0]            rsp_data
);

    localparam int STRB_W = BANK_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int PIPE_D = BANK_RD_LATENCY + 1;

    // Handshake: requester i transfers when req_valid[i] && req_ready[i]; it
    // holds valid and payload until then. req_ready is one-hot or zero.
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] cand;
    logic             grant_any;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        if (reset) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    logic                       sel_wr;
    logic [BANK_ADDR_WIDTH-1:0] sel_addr;
    logic [BANK_DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]          sel_wstrb;

    assign sel_wr    = req_wr[grant_id];
    assign sel_addr  = req_addr[int'(grant_id)*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(grant_id)*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
    assign sel_wstrb = req_wstrb[int'(grant_id)*STRB_W +: STRB_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Data fields keep their last values between commands; only en/wr drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_en    <= 1'b0;
            bank_wr    <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            bank_wstrb <= '0;
        end else if (grant_any) begin
            bank_en    <= 1'b1;
            bank_wr    <= sel_wr;
            bank_addr  <= sel_addr;
            bank_wdata <= sel_wdata;
            bank_wstrb <= sel_wstrb;
        end else begin
            bank_en <= 1'b0;
            bank_wr <= 1'b0;
        end
    end

    // Stage 0 lines up with the bank command; the tail lines up with bank_rdata.
    logic [PIPE_D-1:0]            pipe_valid;
    logic [PIPE_D-1:0][PTR_W-1:0] pipe_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid <= {pipe_valid[PIPE_D-2:0], grant_any && !sel_wr};
            pipe_id    <= {pipe_id[PIPE_D-2:0], grant_id};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (pipe_valid[PIPE_D-1]) begin
                rsp_valid[pipe_id[PIPE_D-1]] <= 1'b1;
                rsp_data                     <= bank_rdata;
            end
        end
    end

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Directed bench for glb_bank_arbiter with a 1-cycle-latency bank model.
module tb_glb_bank_arbiter;

    localparam int NR = 4;
    localparam int AW = 17;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic                 clk;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_wr;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR*SW-1:0]     req_wstrb;
    logic [NR-1:0]        req_ready;
    logic                 bank_en;
    logic                 bank_wr;
    logic [AW-1:0]        bank_addr;
    logic [DW-1:0]        bank_wdata;
    logic [SW-1:0]        bank_wstrb;
    logic [DW-1:0]        bank_rdata;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_data;

    int n_checks;
    int n_pass;

    glb_bank_arbiter #(
        .NUM_REQ(NR), .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .BANK_RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .bank_en(bank_en), .bank_wr(bank_wr), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_wstrb(bank_wstrb), .bank_rdata(bank_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: read data appears the cycle after a read command.
    logic [DW-1:0] mem [int];
    always @(posedge clk) begin
        if (bank_en) begin
            if (bank_wr) begin
                logic [DW-1:0] tmp;
                tmp = mem.exists(int'(bank_addr)) ? mem[int'(bank_addr)] : '0;
                for (int b = 0; b < SW; b++) begin
                    if (bank_wstrb[b]) tmp[b*8 +: 8] = bank_wdata[b*8 +: 8];
                end
                mem[int'(bank_addr)] = tmp;
            end else begin
                bank_rdata <= mem.exists(int'(bank_addr)) ? mem[int'(bank_addr)] : '0;
            end
        end
    end

    function automatic logic [DW-1:0] dval(input int i);
        return {32'hA0A0_0000 | 32'(i), 32'h5555_0000 | 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]            = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = '1;
    endtask

    initial begin
        logic [NR-1:0] exp_g;
        n_checks   = 0;
        n_pass     = 0;
        bank_rdata = '0;
        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_wr     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(32'h20 + i), dval(i));

        // Reset held three cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            next();
            #1;
            chk("rst_ready", DW'(req_ready), '0);
            chk("rst_bank_en", DW'(bank_en), '0);
            chk("rst_rsp_valid", DW'(rsp_valid), '0);
        end
        chk("rst_bank_addr", DW'(bank_addr), '0);
        chk("rst_rsp_data", rsp_data, '0);
        reset = 1'b0;
        #1;
        chk("release_ready", DW'(req_ready), DW'(4'b0001));

        // Round-robin with all four valid
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                next();
                #1;
            end
            exp_g = 4'b0001 << (k % 4);
            chk("rr_grant", DW'(req_ready), DW'(exp_g));
            if (k > 0) chk("rr_addr", DW'(bank_addr), DW'(32'h20 + (k - 1) % 4));
        end
        next();
        req_valid = '0;
        #1;
        chk("rr_last_addr", DW'(bank_addr), DW'(32'h23));
        chk("rr_last_en", DW'(bank_en), DW'(1));
        chk("idle_ready", DW'(req_ready), '0);

        // Pointer skip and wrap: move rr_ptr to 3 by granting req 2 alone
        set_req(2, 1'b1, AW'(32'h42), 64'h42);
        req_valid = 4'b0100;
        #1;
        chk("skip_pre", DW'(req_ready), DW'(4'b0100));
        next();
        set_req(0, 1'b1, AW'(32'h40), 64'h40);
        req_valid = 4'b0101;
        #1;
        chk("skip_wrap0", DW'(req_ready), DW'(4'b0001));
        chk("skip_addr_pre", DW'(bank_addr), DW'(32'h42));
        next();
        #1;
        chk("skip_then2", DW'(req_ready), DW'(4'b0100));
        chk("skip_addr0", DW'(bank_addr), DW'(32'h40));
        next();
        set_req(3, 1'b1, AW'(32'h43), 64'h43);
        req_valid = 4'b1000;
        #1;
        chk("only3", DW'(req_ready), DW'(4'b1000));
        chk("skip_addr2", DW'(bank_addr), DW'(32'h42));
        next();
        req_valid = '0;
        #1;
        chk("only3_addr", DW'(bank_addr), DW'(32'h43));

        // Read routing: req1 writes, req2 reads the same word
        set_req(1, 1'b1, AW'(32'h10), 64'hDEADBEEF_CAFEF00D);
        req_valid = 4'b0010;
        #1;
        chk("wr_grant", DW'(req_ready), DW'(4'b0010));
        next();
        set_req(2, 1'b0, AW'(32'h10), '0);
        req_valid = 4'b0100;
        #1;
        chk("rd_grant", DW'(req_ready), DW'(4'b0100));
        chk("wr_cmd_wr", DW'(bank_wr), DW'(1));
        chk("wr_cmd_addr", DW'(bank_addr), DW'(32'h10));
        chk("wr_cmd_data", bank_wdata, 64'hDEADBEEF_CAFEF00D);
        chk("wr_cmd_strb", DW'(bank_wstrb), DW'(8'hFF));
        next();
        req_valid = '0;
        #1;
        chk("rd_cmd_en", DW'(bank_en), DW'(1));
        chk("rd_cmd_wr", DW'(bank_wr), '0);
        chk("rd_no_rsp1", DW'(rsp_valid), '0);
        next();
        #1;
        chk("wr_no_rsp", DW'(rsp_valid), '0);
        next();
        #1;
        chk("rd_rsp_valid", DW'(rsp_valid), DW'(4'b0100));
        chk("rd_rsp_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
        next();
        #1;
        chk("rd_rsp_drop", DW'(rsp_valid), '0);
        chk("rd_rsp_hold", rsp_data, 64'hDEADBEEF_CAFEF00D);

        // Back-to-back reads req0, req3, req0 (rr_ptr is 3 here)
        set_req(0, 1'b0, AW'(32'h20), '0);
        req_valid = 4'b0001;
        #1;
        chk("b2b_g0", DW'(req_ready), DW'(4'b0001));
        next();
        set_req(3, 1'b0, AW'(32'h22), '0);
        req_valid = 4'b1000;
        #1;
        chk("b2b_g3", DW'(req_ready), DW'(4'b1000));
        chk("b2b_addr0", DW'(bank_addr), DW'(32'h20));
        next();
        set_req(0, 1'b0, AW'(32'h21), '0);
        req_valid = 4'b0001;
        #1;
        chk("b2b_g0b", DW'(req_ready), DW'(4'b0001));
        chk("b2b_addr3", DW'(bank_addr), DW'(32'h22));
        next();
        req_valid = '0;
        #1;
        chk("b2b_rsp0", DW'(rsp_valid), DW'(4'b0001));
        chk("b2b_data0", rsp_data, dval(0));
        chk("b2b_addr0b", DW'(bank_addr), DW'(32'h21));
        next();
        #1;
        chk("b2b_rsp3", DW'(rsp_valid), DW'(4'b1000));
        chk("b2b_data3", rsp_data, dval(2));
        next();
        #1;
        chk("b2b_rsp0b", DW'(rsp_valid), DW'(4'b0001));
        chk("b2b_data0b", rsp_data, dval(1));
        next();
        #1;
        chk("b2b_idle", DW'(rsp_valid), '0);

        // Reset one cycle after a read grant drops the read
        set_req(1, 1'b0, AW'(32'h10), '0);
        req_valid = 4'b0010;
        #1;
        chk("mid_grant", DW'(req_ready), DW'(4'b0010));
        next();
        req_valid = 4'b1111;
        reset     = 1'b1;
        #1;
        chk("mid_rst_ready", DW'(req_ready), '0);
        chk("mid_cmd_en", DW'(bank_en), DW'(1));
        next();
        reset     = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_en_clr", DW'(bank_en), '0);
        chk("mid_rsp_a", DW'(rsp_valid), '0);
        next();
        #1;
        chk("mid_rsp_b", DW'(rsp_valid), '0);
        next();
        req_valid = 4'b1111;
        #1;
        chk("mid_rsp_c", DW'(rsp_valid), '0);
        chk("mid_ptr_reset", DW'(req_ready), DW'(4'b0001));
        next();
        req_valid = '0;
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
